// File: rtl/alu_add_sched_pkg.sv
// alu_add_sched_pkg: shared state encoding, size defaults and result-flag helpers
// for the shared ALU add/sub scheduler.
package alu_add_sched_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Status flags carried with a finished sum
  typedef struct packed {
    logic zero;
    logic neg;
    logic ovf;
  } alu_flags_t;

  // Signed overflow: both addends agree in sign but the sum does not
  function automatic logic calc_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// alu_rr_pick: combinational round-robin picker; grants the first valid requester
// at or after ptr, wrapping upward, and reports its index.
module alu_rr_pick #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] k_s;
  logic           found_s;
  logic           sel_s;

  // Scan from ptr with wrap; the first valid requester seen wins
  always_comb begin
    grant   = '0;
    idx     = '0;
    found_s = 1'b0;
    k_s     = '0;
    sel_s   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k_s        = IDW'((int'(ptr) + i) % NREQ);
      sel_s      = !found_s && valid[k_s];
      grant[k_s] = grant[k_s] | sel_s;
      idx        = sel_s ? k_s : idx;
      found_s    = found_s | sel_s;
    end
  end

  assign any = |valid;

endmodule

// File: rtl/alu_add_sched.sv
// alu_add_sched: round-robin scheduler sharing one add/sub datapath, split into two
// half-width passes. Flag ports are built only when ALU_ADD_SCHED_FLAGS_EN is defined.
module alu_add_sched
  import alu_add_sched_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  parameter  int W    = W_DEF,
  localparam int IDW  = $clog2(NREQ),
  localparam int HALF = W / 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
`ifdef ALU_ADD_SCHED_FLAGS_EN
  output logic              rsp_zero,
  output logic              rsp_neg,
  output logic              rsp_ovf,
`endif
  output logic              rsp_cout
);

  state_t          state_r, state_nx_s;
  logic [IDW-1:0]  ptr_r, id_r, pick_idx_s;
  logic [NREQ-1:0] pick_grant_s;
  logic            pick_any_s;
  logic [W-1:0]    op_a_r, op_b_r, sum_r, full_s;
  logic            cin_r, c_mid_r, cout_r, rsp_valid_r;
  logic [HALF-1:0] lo_r;
  logic [HALF:0]   lo_add_s, hi_add_s;

  alu_rr_pick #(.NREQ(NREQ)) u_pick (
    .valid (req_valid),
    .ptr   (ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

  // Two half-width ripple adders; op_b_r is already inverted for subtract
  assign lo_add_s = {1'b0, op_a_r[HALF-1:0]} + {1'b0, op_b_r[HALF-1:0]} + {{HALF{1'b0}}, cin_r};
  assign hi_add_s = {1'b0, op_a_r[W-1:HALF]} + {1'b0, op_b_r[W-1:HALF]} + {{HALF{1'b0}}, c_mid_r};
  assign full_s   = {hi_add_s[HALF-1:0], lo_r};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state; the grant is only offered while idle
  always_comb begin
    state_nx_s = state_r;
    req_ready  = '0;
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_nx_s = ST_LO;
          req_ready  = pick_grant_s;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LO:   state_nx_s = ST_HI;
      ST_HI:   state_nx_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RESP;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Operand capture at grant, then low pass, high pass and response hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r       <= '0;
      id_r        <= '0;
      op_a_r      <= '0;
      op_b_r      <= '0;
      cin_r       <= 1'b0;
      lo_r        <= '0;
      c_mid_r     <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            op_a_r <= req_a[int'(pick_idx_s) * W +: W];
            op_b_r <= req_b[int'(pick_idx_s) * W +: W] ^ {W{req_sub[pick_idx_s]}};
            cin_r  <= req_sub[pick_idx_s];
            id_r   <= pick_idx_s;
            ptr_r  <= (pick_idx_s == IDW'(NREQ - 1)) ? '0 : pick_idx_s + IDW'(1);
          end
        end
        ST_LO: begin
          lo_r    <= lo_add_s[HALF-1:0];
          c_mid_r <= lo_add_s[HALF];
        end
        ST_HI: begin
          sum_r       <= full_s;
          cout_r      <= hi_add_s[HALF];
          rsp_valid_r <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
          end
        end
        default: rsp_valid_r <= 1'b0;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = id_r;
  assign rsp_sum   = sum_r;
  assign rsp_cout  = cout_r;

`ifdef ALU_ADD_SCHED_FLAGS_EN
  alu_flags_t flags_r;

  // Flags are captured with the final sum and held through the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= '0;
    end else if (state_r == ST_HI) begin
      flags_r.zero <= (full_s == '0);
      flags_r.neg  <= hi_add_s[HALF-1];
      flags_r.ovf  <= calc_ovf(op_a_r[W-1], op_b_r[W-1], hi_add_s[HALF-1]);
    end
  end

  assign rsp_zero = flags_r.zero;
  assign rsp_neg  = flags_r.neg;
  assign rsp_ovf  = flags_r.ovf;
`endif

endmodule

// File: tb/tb_alu_add_sched.sv
// tb_alu_add_sched: scoreboard bench for the round-robin add/sub scheduler.
// Flag checks are compiled in when ALU_ADD_SCHED_FLAGS_EN is defined.
module tb_alu_add_sched;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = $clog2(NREQ);

  typedef struct {
    int           id;
    logic [W-1:0] sum;
    logic         cout;
    logic         zero;
    logic         neg;
    logic         ovf;
    int           gcyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready, req_sub;
  logic [NREQ*W-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready, rsp_cout;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
`ifdef ALU_ADD_SCHED_FLAGS_EN
  logic              rsp_zero, rsp_neg, rsp_ovf;
  logic              last_zero, last_neg, last_ovf;
`endif

  exp_t         sb[$];
  int           grant_log[$];
  int           grant_cyc_log[$];
  int           remain[NREQ];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           exp_ptr = 0;
  int           pend_g = -1;
  int           last_id, last_gcyc, last_hs_cyc;
  logic [W-1:0] last_sum;
  logic         last_cout;
  logic         rsp_valid_prev = 1'b0;

  alu_add_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
`ifdef ALU_ADD_SCHED_FLAGS_EN
    .rsp_zero  (rsp_zero),
    .rsp_neg   (rsp_neg),
    .rsp_ovf   (rsp_ovf),
`endif
    .rsp_cout  (rsp_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end

  // Reference result computed at full width with signed arithmetic for overflow
  function automatic exp_t model(input int i);
    exp_t         e;
    logic [W-1:0] a, b;
    longint       sa, sbv, r;
    a   = req_a[i*W +: W];
    b   = req_b[i*W +: W];
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (req_sub[i]) begin
      r      = sa - sbv;
      e.sum  = a - b;
      e.cout = (a >= b);
    end else begin
      r      = sa + sbv;
      e.sum  = a + b;
      e.cout = (({1'b0, a} + {1'b0, b}) > 33'h0_FFFF_FFFF);
    end
    e.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.zero = (e.sum == '0);
    e.neg  = e.sum[W-1];
    e.id   = i;
    e.gcyc = cyc;
    return e;
  endfunction

  task automatic load_rand(input int i);
    req_a[i*W +: W] = $urandom();
    req_b[i*W +: W] = $urandom();
    req_sub[i]      = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input int n);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_sub[i]      = sub;
    req_valid[i]    = 1'b1;
    remain[i]       = n;
  endtask

  // One clock: observe at negedge, then update requesters just after the rising edge
  task automatic step();
    exp_t            e;
    int              g;
    logic [NREQ-1:0] oh;
    @(negedge clk);
    if (rsp_valid && !rsp_valid_prev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: rsp_valid rose with id=%0d, expected no response", rsp_id);
      end else if (cyc - sb[0].gcyc != 3) begin
        errors++;
        $display("FAIL latency: got %0d cycles, expected 3", cyc - sb[0].gcyc);
      end
    end
    rsp_valid_prev = rsp_valid;
    if (rsp_valid && rsp_ready && sb.size() != 0) begin
      e           = sb.pop_front();
      last_id     = int'(rsp_id);
      last_sum    = rsp_sum;
      last_cout   = rsp_cout;
      last_hs_cyc = cyc;
      checks++;
      if (int'(rsp_id) != e.id) begin
        errors++; $display("FAIL rsp_id: got %0d, expected %0d", rsp_id, e.id);
      end
      checks++;
      if (rsp_sum !== e.sum) begin
        errors++; $display("FAIL rsp_sum: got %h, expected %h", rsp_sum, e.sum);
      end
      checks++;
      if (rsp_cout !== e.cout) begin
        errors++; $display("FAIL rsp_cout: got %b, expected %b", rsp_cout, e.cout);
      end
`ifdef ALU_ADD_SCHED_FLAGS_EN
      last_zero = rsp_zero;
      last_neg  = rsp_neg;
      last_ovf  = rsp_ovf;
      checks++;
      if ({rsp_zero, rsp_neg, rsp_ovf} !== {e.zero, e.neg, e.ovf}) begin
        errors++;
        $display("FAIL rsp_flags: got zno=%b%b%b, expected %b%b%b",
                 rsp_zero, rsp_neg, rsp_ovf, e.zero, e.neg, e.ovf);
      end
`endif
    end
    if (req_ready !== '0) begin
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(exp_ptr + k) % NREQ]) g = (exp_ptr + k) % NREQ;
      end
      oh = '0;
      if (g >= 0) oh[g] = 1'b1;
      checks++;
      if (req_ready !== oh) begin
        errors++; $display("FAIL grant: got req_ready=%b, expected %b", req_ready, oh);
      end
      if (g >= 0) begin
        sb.push_back(model(g));
        grant_log.push_back(g);
        grant_cyc_log.push_back(cyc);
        last_gcyc = cyc;
        exp_ptr   = (g + 1) % NREQ;
        pend_g    = g;
      end
    end
    @(posedge clk);
    #1;
    if (pend_g >= 0) begin
      remain[pend_g]--;
      if (remain[pend_g] > 0) load_rand(pend_g);
      else req_valid[pend_g] = 1'b0;
      pend_g = -1;
    end
  endtask

  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || req_valid != '0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: %0d responses outstanding after %0d cycles, expected 0",
               tag, sb.size(), budget);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    sb.delete();
    grant_log.delete();
    grant_cyc_log.delete();
    exp_ptr        = 0;
    pend_g         = -1;
    rsp_valid_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, expected 0", rsp_valid); end
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b, expected 0", req_ready); end
    checks++;
    if ({rsp_id, rsp_sum, rsp_cout} !== '0) begin
      errors++; $display("FAIL reset_rsp: got id=%0d sum=%h cout=%b, expected all 0", rsp_id, rsp_sum, rsp_cout);
    end
`ifdef ALU_ADD_SCHED_FLAGS_EN
    checks++;
    if ({rsp_zero, rsp_neg, rsp_ovf} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b%b%b, expected 000", rsp_zero, rsp_neg, rsp_ovf);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_add_carry();
    issue(2, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1);
    drain(20, "add");
    checks++;
    if (last_sum !== 32'h0001_0000 || last_cout !== 1'b0 || last_id != 2) begin
      errors++; $display("FAIL add_carry: got sum=%h cout=%b id=%0d, expected 00010000 0 2", last_sum, last_cout, last_id);
    end
  endtask

  task automatic test_sub();
    issue(0, 32'd5, 32'd7, 1'b1, 1);
    drain(20, "sub");
    checks++;
    if (last_sum !== 32'hFFFF_FFFE || last_cout !== 1'b0 || last_id != 0) begin
      errors++; $display("FAIL sub: got sum=%h cout=%b id=%0d, expected fffffffe 0 0", last_sum, last_cout, last_id);
    end
`ifdef ALU_ADD_SCHED_FLAGS_EN
    checks++;
    if (last_neg !== 1'b1 || last_ovf !== 1'b0) begin
      errors++; $display("FAIL sub_flags: got neg=%b ovf=%b, expected 1 0", last_neg, last_ovf);
    end
`endif
  endtask

  task automatic test_ovf_zero();
    issue(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1);
    drain(20, "ovf");
    checks++;
    if (last_sum !== 32'h8000_0000 || last_cout !== 1'b0) begin
      errors++; $display("FAIL ovf_sum: got sum=%h cout=%b, expected 80000000 0", last_sum, last_cout);
    end
`ifdef ALU_ADD_SCHED_FLAGS_EN
    checks++;
    if (last_ovf !== 1'b1 || last_neg !== 1'b1 || last_zero !== 1'b0) begin
      errors++; $display("FAIL ovf_flags: got ovf=%b neg=%b zero=%b, expected 1 1 0", last_ovf, last_neg, last_zero);
    end
`endif
    issue(3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1);
    drain(20, "zero");
    checks++;
    if (last_sum !== 32'h0000_0000 || last_cout !== 1'b1 || last_id != 3) begin
      errors++; $display("FAIL zero_sum: got sum=%h cout=%b id=%0d, expected 00000000 1 3", last_sum, last_cout, last_id);
    end
`ifdef ALU_ADD_SCHED_FLAGS_EN
    checks++;
    if (last_zero !== 1'b1 || last_ovf !== 1'b0) begin
      errors++; $display("FAIL zero_flags: got zero=%b ovf=%b, expected 1 0", last_zero, last_ovf);
    end
`endif
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      load_rand(i);
      req_valid[i] = 1'b1;
      remain[i]    = 2;
    end
    drain(100, "fair");
    checks++;
    if (grant_log.size() != 2 * NREQ) begin
      errors++; $display("FAIL fair_count: got %0d grants, expected %0d", grant_log.size(), 2 * NREQ);
    end else begin
      for (int k = 0; k < 2 * NREQ; k++) begin
        checks++;
        if (grant_log[k] != k % NREQ) begin
          errors++; $display("FAIL fair_order[%0d]: got %0d, expected %0d", k, grant_log[k], k % NREQ);
        end
      end
      for (int k = 1; k < 2 * NREQ; k++) begin
        checks++;
        if (grant_cyc_log[k] - grant_cyc_log[k-1] != 4) begin
          errors++; $display("FAIL back_to_back[%0d]: got gap %0d, expected 4", k, grant_cyc_log[k] - grant_cyc_log[k-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n, hs;
    rsp_ready = 1'b0;
    issue(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1);
    issue(1, 32'h0000_000A, 32'h0000_0003, 1'b1, 1);
    n = 0;
    while (!rsp_valid && n < 10) begin step(); n++; end
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 32'h2345_6789 || rsp_id !== 2'd0 || rsp_cout !== 1'b0) begin
        errors++; $display("FAIL bp_frozen: got valid=%b sum=%h id=%0d cout=%b, expected 1 23456789 0 0",
                           rsp_valid, rsp_sum, rsp_id, rsp_cout);
      end
      checks++;
      if (req_ready !== '0) begin
        errors++; $display("FAIL bp_no_grant: got req_ready=%b, expected 0", req_ready);
      end
    end
    rsp_ready = 1'b1;
    step();
    hs = last_hs_cyc;
    step();
    checks++;
    if (last_gcyc != hs + 1) begin
      errors++; $display("FAIL bp_regrant: got grant cycle %0d, expected %0d", last_gcyc, hs + 1);
    end
    drain(20, "bp");
  endtask

  task automatic test_reset_mid();
    int n;
    rsp_ready = 1'b1;
    issue(1, 32'h0000_0001, 32'h0000_0002, 1'b0, 1);
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_hi_valid: got %b, expected 0", rsp_valid); end
    do_reset();
    rsp_ready = 1'b0;
    issue(2, 32'h0000_0003, 32'h0000_0004, 1'b0, 1);
    n = 0;
    while (!rsp_valid && n < 10) begin step(); n++; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_async_drop: got rsp_valid=%b, expected 0", rsp_valid); end
    do_reset();
    issue(1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1);
    issue(3, 32'h0000_0030, 32'h0000_0040, 1'b1, 1);
    drain(30, "post_reset");
    checks++;
    if (grant_log.size() == 0 || grant_log[0] != 1) begin
      errors++; $display("FAIL reset_ptr: got first grant %0d, expected 1", grant_log.size() == 0 ? -1 : grant_log[0]);
    end
  endtask

  initial begin
    req_valid = '0;
    req_sub   = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    for (int i = 0; i < NREQ; i++) remain[i] = 0;
    test_reset();
    test_add_carry();
    test_sub();
    test_ovf_zero();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
